// File: rtl/i2c_codec_responder_pkg.sv
// Shared definitions for the I2C codec responder: FSM states and fixed register indices.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    localparam logic [6:0] RESET_REG_IDX    = 7'h0F;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

    // Address byte matches only for a write to this device
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
        return (addr_byte[7:1] == dev) && !addr_byte[0];
    endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Open-drain I2C pad signals between the bus side and the responder.
interface i2c_codec_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_codec_responder_bus_filter.sv
// Pad conditioning: 2-flop synchronizers, 3-sample majority filter, SCL edges, START/STOP.
module i2c_bus_filter (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic       scl_p0, scl_p1, sda_p0, sda_p1;
    logic [2:0] scl_win_p2, sda_win_p2;
    logic       scl_f, scl_q, sda_q;

    function automatic logic majority(input logic [2:0] w);
        return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    endfunction

    // Everything idles high so a reset never looks like a bus edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_p0     <= 1'b1;
            scl_p1     <= 1'b1;
            sda_p0     <= 1'b1;
            sda_p1     <= 1'b1;
            scl_win_p2 <= 3'b111;
            sda_win_p2 <= 3'b111;
            scl_f      <= 1'b1;
            sda_f      <= 1'b1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_p0     <= scl_in;
            scl_p1     <= scl_p0;
            sda_p0     <= sda_in;
            sda_p1     <= sda_p0;
            scl_win_p2 <= {scl_win_p2[1:0], scl_p1};
            sda_win_p2 <= {sda_win_p2[1:0], sda_p1};
            scl_f      <= majority(scl_win_p2);
            sda_f      <= majority(sda_win_p2);
            scl_q      <= scl_f;
            sda_q      <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only register responder: addr byte, {index, data[8]} byte, data[7:0] byte.
module i2c_codec_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int          NUM_REGS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    i2c_codec_responder_if.slave         bus,
    output logic                         wr_en,
    output logic [6:0]                   wr_addr,
    output logic [8:0]                   wr_data,
    input  logic [6:0]                   rd_addr,
    output logic [8:0]                   rd_data,
    output logic                         busy
);

    logic       sda_f, scl_rise, scl_fall, start_det, stop_det;
    state_t     state, state_n;
    logic [2:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n;
    logic [6:0] reg_idx, idx_n, wr_addr_n;
    logic       d8, d8_n, ack_on, ack_on_n, oe, oe_n, busy_n, wr_en_n;
    logic [8:0] wr_data_n;
    logic [7:0] byte_in;
    logic       last_bit;
    logic [8:0] regs [NUM_REGS];

    i2c_bus_filter u_filter (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in  = {shreg[6:0], sda_f};
    assign last_bit = (bit_cnt == 3'd7);
    assign bus.sda_oe = oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            reg_idx <= '0;
            d8      <= 1'b0;
            ack_on  <= 1'b0;
            oe      <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shreg   <= sh_n;
            reg_idx <= idx_n;
            d8      <= d8_n;
            ack_on  <= ack_on_n;
            oe      <= oe_n;
            busy    <= busy_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = bit_cnt;
        sh_n      = shreg;
        idx_n     = reg_idx;
        d8_n      = d8;
        ack_on_n  = ack_on;
        oe_n      = oe;
        busy_n    = busy;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        if (stop_det) begin
            state_n  = IDLE;
            oe_n     = 1'b0;
            ack_on_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n  = ADDR;
            cnt_n    = '0;
            oe_n     = 1'b0;
            ack_on_n = 1'b0;
            busy_n   = 1'b1;
        end else begin
            case (state)
                ADDR, REG, DATA: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (state == ADDR) begin
                                state_n = addr_match(byte_in, DEV_ADDR) ? ADDR_ACK : IGNORE;
                            end else if (state == REG) begin
                                idx_n   = shreg[6:0];
                                d8_n    = sda_f;
                                state_n = REG_ACK;
                            end else begin
                                wr_en_n   = 1'b1;
                                wr_addr_n = reg_idx;
                                wr_data_n = {d8, byte_in};
                                state_n   = DATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall after the byte drives ACK, the second one ends it
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            oe_n     = 1'b1;
                            ack_on_n = 1'b1;
                        end else begin
                            oe_n     = 1'b0;
                            ack_on_n = 1'b0;
                            cnt_n    = '0;
                            case (state)
                                ADDR_ACK: state_n = REG;
                                REG_ACK:  state_n = DATA;
                                default:  state_n = IGNORE;
                            endcase
                        end
                    end
                end
                default: oe_n = 1'b0;
            endcase
        end
    end

    // Writing the reset register clears the whole file instead of storing data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == RESET_REG_IDX) regs[i] <= '0;
                else if (wr_addr == 7'(i))    regs[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) rd_data = regs[i];
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Scoreboard bench for i2c_codec_responder: bit-banged I2C master with directed transfers.
module tb_i2c_codec_responder;

    localparam int Q = 10;

    typedef struct {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       wr_en, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [6:0] rd_addr = '0;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  oe_cnt = 0;

    i2c_codec_responder_if bus();

    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_codec_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.sda_oe) oe_cnt++;
            if (!reset && wr_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(e.addr));
                    chk("wr_data", int'(wr_data), int'(e.data));
                end
            end
        end
    endtask

    task automatic waitq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; waitq();
        scl_drv = 1'b1; waitq();
        sda_drv = 1'b0; waitq();
        scl_drv = 1'b0; waitq();
    endtask

    task automatic i2c_stop();
        waitq(); sda_drv = 1'b0;
        waitq(); scl_drv = 1'b1;
        waitq(); sda_drv = 1'b1;
        waitq();
    endtask

    task automatic send_bit(input logic b);
        waitq(); sda_drv = b;
        waitq(); scl_drv = 1'b1;
        waitq(); waitq();
        scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int exp_ack, input string name);
        int a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        waitq(); sda_drv = 1'b1;
        waitq(); scl_drv = 1'b1;
        waitq(); a = bus.sda_in ? 0 : 1;
        waitq(); scl_drv = 1'b0;
        chk(name, a, exp_ack);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [8:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] a, input int exp);
        rd_addr = a;
        @(negedge clk);
        chk(name, int'(rd_data), exp);
    endtask

    task automatic write3(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        i2c_start();
        send_byte(b1, 1, "ack_addr");
        send_byte(b2, 1, "ack_reg");
        send_byte(b3, 1, "ack_data");
        i2c_stop();
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int oe0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", int'(bus.sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rd_chk("rst_reg0", 7'd0, 0);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);

        // Basic write: reg 2 <= 0x074
        push_wr(7'h02, 9'h074);
        i2c_start();
        send_byte(8'h34, 1, "w1_ack_addr");
        chk("w1_busy", int'(busy), 1);
        send_byte(8'h04, 1, "w1_ack_reg");
        send_byte(8'h74, 1, "w1_ack_data");
        i2c_stop();
        repeat (4) @(posedge clk);
        chk("w1_busy_after_stop", int'(busy), 0);
        rd_chk("w1_reg2", 7'h02, 9'h074);
        chk("w1_queue", exp_q.size(), 0);

        // Wrong address, then read bit: no ACK, no write
        oe0 = oe_cnt;
        i2c_start();
        send_byte(8'h36, 0, "nack_addr36");
        send_byte(8'h04, 0, "nack_b1");
        send_byte(8'h55, 0, "nack_b2");
        i2c_stop();
        i2c_start();
        send_byte(8'h35, 0, "nack_read_bit");
        i2c_stop();
        chk("nack_oe_count", oe_cnt - oe0, 0);
        rd_chk("nack_reg2", 7'h02, 9'h074);
        rd_chk("nack_reg4", 7'h04, 0);

        // Reg 7 <= 0x155, then an aborted transfer leaves it alone
        push_wr(7'h07, 9'h155);
        write3(8'h34, 8'h0F, 8'h55);
        rd_chk("r7_written", 7'h07, 9'h155);
        i2c_start();
        send_byte(8'h34, 1, "abort_ack_addr");
        send_byte(8'h0E, 1, "abort_ack_reg");
        i2c_stop();
        repeat (4) @(posedge clk);
        rd_chk("abort_reg7", 7'h07, 9'h155);
        chk("abort_queue", exp_q.size(), 0);

        // Out-of-range index: ACKed, pulses, no storage; extra byte is not ACKed
        push_wr(7'h10, 9'h0AB);
        i2c_start();
        send_byte(8'h34, 1, "oor_ack_addr");
        send_byte(8'h20, 1, "oor_ack_reg");
        send_byte(8'hAB, 1, "oor_ack_data");
        send_byte(8'hFF, 0, "oor_extra_nack");
        i2c_stop();
        repeat (4) @(posedge clk);
        rd_chk("oor_rd16", 7'h10, 0);
        rd_chk("oor_reg0", 7'h00, 0);
        rd_chk("oor_reg7", 7'h07, 9'h155);

        // Reset register clears everything
        push_wr(7'h05, 9'h006);
        write3(8'h34, 8'h0A, 8'h06);
        rd_chk("pre_reg5", 7'h05, 9'h006);
        push_wr(7'h0F, 9'h000);
        write3(8'h34, 8'h1E, 8'h00);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("clr_reg%0d", i), 7'(i), 0);

        // Repeated START: only the second transfer commits
        push_wr(7'h09, 9'h001);
        i2c_start();
        send_byte(8'h34, 1, "rs_ack_addr1");
        send_byte(8'h0C, 1, "rs_ack_reg1");
        i2c_start();
        send_byte(8'h34, 1, "rs_ack_addr2");
        send_byte(8'h12, 1, "rs_ack_reg2");
        send_byte(8'h01, 1, "rs_ack_data");
        i2c_stop();
        repeat (4) @(posedge clk);
        rd_chk("rs_reg9", 7'h09, 9'h001);
        rd_chk("rs_reg6", 7'h06, 0);
        chk("rs_queue", exp_q.size(), 0);

        // Reset while the data byte is being ACKed
        push_wr(7'h04, 9'h055);
        i2c_start();
        send_byte(8'h34, 1, "ra_ack_addr");
        send_byte(8'h08, 1, "ra_ack_reg");
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h55 >> i));
        waitq();
        chk("ra_oe_before", int'(bus.sda_oe), 1);
        #2 reset = 1'b1;
        #1;
        chk("ra_oe_async", int'(bus.sda_oe), 0);
        chk("ra_busy", int'(busy), 0);
        rd_chk("ra_reg4", 7'h04, 0);
        rd_chk("ra_reg9", 7'h09, 0);
        chk("ra_queue", exp_q.size(), 0);
        sda_drv = 1'b1;
        scl_drv = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        oe0 = oe_cnt;
        repeat (40) @(posedge clk);
        chk("ra_no_glitch", oe_cnt - oe0, 0);
        chk("ra_busy_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address the block answers to.
REQ-002 Parameter NUM_REGS, default 16, number of 9-bit registers in the register file (max 128).
REQ-003 clk  input  1  system clock; at least 8x the SCL rate.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 scl_in  input  1  raw I2C clock from the pad, asynchronous.
REQ-006 sda_in  input  1  raw I2C data from the pad, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release SDA (open-drain).
REQ-008 wr_en  output  1  one-cycle pulse when a register write is committed.
REQ-009 wr_addr  output  7  register index of the committed write.
REQ-010 wr_data  output  9  9-bit data of the committed write.
REQ-011 rd_addr  input  7  local readback index.
REQ-012 rd_data  output  9  combinational register content at rd_addr; 0 if rd_addr >= NUM_REGS.
REQ-013 busy  output  1  high from a START until the following STOP.

Function
REQ-014 scl_in and sda_in SHALL pass through 2-flop synchronizers, then a 3-sample majority filter before edge detection.
REQ-015 START = filtered SDA falls while SCL is high; STOP = filtered SDA rises while SCL is high; both are detected in any state.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 START in any state SHALL go to ADDR, clear the bit counter, and set busy (repeated START supported).
REQ-018 STOP in any state SHALL go to IDLE, release SDA and clear busy; any partial transfer is discarded.
REQ-019 Bits SHALL be sampled MSB-first on the filtered SCL rising edge; the bit counter runs 0..7.
REQ-020 ADDR: after 8 bits, match = (byte[7:1] == DEV_ADDR) && (byte[0] == 0); match -> ADDR_ACK; mismatch or read bit -> IGNORE with no ACK.
REQ-021 In every *_ACK state, sda_oe SHALL assert on the SCL falling edge after the 8th bit and deassert on the next SCL falling edge, then the FSM advances.
REQ-022 REG byte = {reg_index[6:0], data[8]}; it is always ACKed; REG_ACK -> DATA.
REQ-023 DATA byte = data[7:0]; it is always ACKed. The write commits in the cycle after the 8th DATA bit is sampled: wr_en pulses for one cycle with wr_addr and wr_data.
REQ-024 If reg_index == 7'h0F (reset register), all registers SHALL clear to 0 and wr_en still pulses with addr 0x0F.
REQ-025 If reg_index >= NUM_REGS and != 0x0F, the byte is ACKed and the register file is not written; wr_en still pulses.
REQ-026 After DATA_ACK the FSM SHALL go to IGNORE; further bytes are not ACKed and nothing further is written.
REQ-027 IGNORE: sda_oe = 0; the FSM waits for START or STOP.
REQ-028 Register file is written only at commit; rd_data reflects the new value the cycle after wr_en.

Reset
REQ-029 While reset is high: FSM = IDLE, sda_oe = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, all registers = 0, synchronizers = 1 (bus idle).
REQ-030 Reset asserted mid-ACK SHALL release SDA asynchronously, with no glitch low afterward.

Structure
REQ-031 A shared package i2c_pkg SHALL hold the FSM state enum, the reset register index constant 7'h0F, and the default device address 7'h1A.
REQ-032 One sub-module, i2c_bus_filter (synchronizer, majority filter, SCL rise/fall, START/STOP detect), SHALL be instantiated once.

Verification
REQ-033 Write 0x34, 0x04, 0x74 with STOP -> 3 ACKs, wr_en pulse with addr 0x02 and data 0x074; rd_data(2) = 0x074.
REQ-034 Address byte 0x36 then 2 bytes -> sda_oe never asserts, no wr_en, registers unchanged.
REQ-035 Write 0x34, 0x0E (reg 7 with data[8] = 0), then STOP before the data byte -> 2 ACKs, no wr_en, reg 7 unchanged.
REQ-036 Preload reg 2 = 0x074 and reg 5 = 0x006, then write 0x34, 0x1E, 0x00 -> wr_en with addr 0x0F; all registers read 0.
REQ-037 Write 0x34, 0x0C, then repeated START, 0x34, 0x12, 0x01 -> single wr_en with addr 0x09 and data 0x001.
REQ-038 Assert reset during DATA_ACK -> sda_oe = 0 the same cycle, busy = 0, all registers = 0.
